// File: rtl/video_source_mux.sv
// Pixel source selector: built-in test patterns or external RGB sources, with a two-stage
// pipeline. A new selection is taken only at the start of vsync so a frame never tears.
module video_source_mux #(
  parameter int   HOR_ACTIVE_PIXELS = 640,
  parameter int   VER_ACTIVE_PIXELS = 480,
  parameter int   COLOR_WIDTH       = 8,
  parameter int   NUM_EXT           = 2,
  parameter int   SEL_WIDTH         = 4,
  parameter int   CHECKER_LOG2      = 5,
  parameter logic VS_POLARITY       = 1'b0,
  parameter logic HS_POLARITY       = 1'b0
) (
  input  logic                                   clk_rgb,
  input  logic                                   rst_n,
  input  logic                                   ce,
  input  logic [SEL_WIDTH-1:0]                   sel,
  input  logic [$clog2(HOR_ACTIVE_PIXELS)-1:0]   x,
  input  logic [$clog2(VER_ACTIVE_PIXELS)-1:0]   y,
  input  logic                                   hs_in,
  input  logic                                   vs_in,
  input  logic                                   de_in,
  input  logic [NUM_EXT*3*COLOR_WIDTH-1:0]       ext_rgb,
  output logic [COLOR_WIDTH-1:0]                 r,
  output logic [COLOR_WIDTH-1:0]                 g,
  output logic [COLOR_WIDTH-1:0]                 b,
  output logic                                   hs,
  output logic                                   vs,
  output logic                                   de,
  output logic [SEL_WIDTH-1:0]                   sel_active
);

  localparam int CW    = COLOR_WIDTH;
  localparam int BAR_W = HOR_ACTIVE_PIXELS / 8;

  logic [SEL_WIDTH-1:0] sel_meta;
  logic [SEL_WIDTH-1:0] sel_sync;
  logic                 vs_prev;
  logic                 frame_start;

  logic [2:0]           bar_idx;
  logic [CW-1:0]        dec_r;
  logic [CW-1:0]        dec_g;
  logic [CW-1:0]        dec_b;

  logic [CW-1:0]        r1;
  logic [CW-1:0]        g1;
  logic [CW-1:0]        b1;
  logic                 hs1;
  logic                 vs1;
  logic                 de1;

  assign frame_start = (vs_in == VS_POLARITY) && (vs_prev != VS_POLARITY);

  // Multi-bit skew through the synchroniser is harmless: sel_sync is only sampled at vsync.
  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta   <= '0;
      sel_sync   <= '0;
      vs_prev    <= ~VS_POLARITY;
      sel_active <= '0;
    end else if (ce) begin
      sel_meta <= sel;
      sel_sync <= sel_meta;
      vs_prev  <= vs_in;
      if (frame_start) begin
        sel_active <= sel_sync;
      end
    end
  end

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x) >= k * BAR_W) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
  end

  always_comb begin
    dec_r = '0;
    dec_g = '0;
    dec_b = '0;
    case (int'(sel_active))
      1: dec_r = '1;
      2: dec_g = '1;
      3: dec_b = '1;
      4: begin
        // Bar order white..black falls out of the index bits directly.
        dec_r = {CW{~bar_idx[1]}};
        dec_g = {CW{~bar_idx[2]}};
        dec_b = {CW{~bar_idx[0]}};
      end
      5: begin
        dec_r = {CW{x[CHECKER_LOG2] ^ y[CHECKER_LOG2]}};
        dec_g = {CW{x[CHECKER_LOG2] ^ y[CHECKER_LOG2]}};
        dec_b = {CW{x[CHECKER_LOG2] ^ y[CHECKER_LOG2]}};
      end
      default: begin
        for (int k = 0; k < NUM_EXT; k++) begin
          if (int'(sel_active) == 6 + k) begin
            {dec_r, dec_g, dec_b} = ext_rgb[k*3*CW +: 3*CW];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
      hs1 <= ~HS_POLARITY;
      vs1 <= ~VS_POLARITY;
      de1 <= 1'b0;
      r   <= '0;
      g   <= '0;
      b   <= '0;
      hs  <= ~HS_POLARITY;
      vs  <= ~VS_POLARITY;
      de  <= 1'b0;
    end else if (ce) begin
      r1  <= dec_r;
      g1  <= dec_g;
      b1  <= dec_b;
      hs1 <= hs_in;
      vs1 <= vs_in;
      de1 <= de_in;
      r   <= de1 ? r1 : '0;
      g   <= de1 ? g1 : '0;
      b   <= de1 ? b1 : '0;
      hs  <= hs1;
      vs  <= vs1;
      de  <= de1;
    end
  end

endmodule

// File: tb/tb_video_source_mux.sv
// Bench for video_source_mux: table-driven pixel vectors plus hand sequences, all checked
// through a scoreboard queue that models the two-cycle pipeline and frame-boundary selection.
module tb_video_source_mux;

  localparam int CW = 8;
  localparam int NE = 2;
  localparam int SW = 4;
  localparam int XW = 10;
  localparam int YW = 9;

  logic               clk_rgb = 1'b0;
  logic               rst_n   = 1'b0;
  logic               ce      = 1'b1;
  logic [SW-1:0]      sel     = '0;
  logic [XW-1:0]      x       = '0;
  logic [YW-1:0]      y       = '0;
  logic               hs_in   = 1'b1;
  logic               vs_in   = 1'b1;
  logic               de_in   = 1'b0;
  logic [NE*3*CW-1:0] ext_rgb = 48'hABCDEF_123456;
  logic [CW-1:0]      r, g, b;
  logic               hs, vs, de;
  logic [SW-1:0]      sel_active;

  video_source_mux dut (
    .clk_rgb    (clk_rgb),
    .rst_n      (rst_n),
    .ce         (ce),
    .sel        (sel),
    .x          (x),
    .y          (y),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .ext_rgb    (ext_rgb),
    .r          (r),
    .g          (g),
    .b          (b),
    .hs         (hs),
    .vs         (vs),
    .de         (de),
    .sel_active (sel_active)
  );

  always #5 clk_rgb = ~clk_rgb;

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  typedef struct {
    logic [3:0]  mode;
    logic [9:0]  xv;
    logic [8:0]  yv;
    logic        dev;
    logic [23:0] rgb;
  } vec_t;

  exp_t       sb[$];
  exp_t       last_exp;
  exp_t       reset_exp;
  vec_t       vecs[$];
  logic [3:0] model_sel;
  logic [3:0] hist1;
  logic [3:0] hist2;
  logic       vs_prev_m;
  int         checks = 0;
  int         passes = 0;

  function automatic logic [23:0] modelRgb(input logic [3:0] m, input logic [9:0] xv,
                                           input logic [8:0] yv);
    logic [23:0] bars [8];
    int idx;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (m)
      4'd1: return 24'hFF0000;
      4'd2: return 24'h00FF00;
      4'd3: return 24'h0000FF;
      4'd4: begin
        idx = int'(xv) / 80;
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      4'd5: return (xv[5] ^ yv[5]) ? 24'hFFFFFF : 24'h000000;
      4'd6: return ext_rgb[23:0];
      4'd7: return ext_rgb[47:24];
      default: return 24'h000000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input exp_t e, input logic [3:0] sa);
    checks++;
    if ({r, g, b} === e.rgb && hs === e.hs && vs === e.vs && de === e.de && sel_active === sa)
      passes++;
    else
      $display("[TB] FAIL %s: got rgb=%h hs=%b vs=%b de=%b sel_active=%0d, expected rgb=%h hs=%b vs=%b de=%b sel_active=%0d",
               name, {r, g, b}, hs, vs, de, sel_active, e.rgb, e.hs, e.vs, e.de, sa);
  endtask

  task automatic resetModel();
    sb.delete();
    model_sel = '0;
    hist1     = '0;
    hist2     = '0;
    vs_prev_m = 1'b1;
    last_exp  = reset_exp;
  endtask

  // One clock of stimulus; enabled cycles push an expectation, and outputs are compared
  // once the expectation from two enabled cycles back reaches the front of the queue.
  task automatic applyStimulus(input string name, input logic ce_v, input logic de_v,
                               input logic hs_v, input logic vs_v, input logic [9:0] x_v,
                               input logic [8:0] y_v, input logic use_tbl,
                               input logic [23:0] tbl_rgb);
    exp_t e;
    ce    = ce_v;
    de_in = de_v;
    hs_in = hs_v;
    vs_in = vs_v;
    x     = x_v;
    y     = y_v;
    if (ce_v) begin
      e.rgb = de_v ? (use_tbl ? tbl_rgb : modelRgb(model_sel, x_v, y_v)) : 24'h0;
      e.hs  = hs_v;
      e.vs  = vs_v;
      e.de  = de_v;
      sb.push_back(e);
      if (vs_v == 1'b0 && vs_prev_m == 1'b1) model_sel = hist2;
      hist2     = hist1;
      hist1     = sel;
      vs_prev_m = vs_v;
    end
    @(posedge clk_rgb);
    #1;
    if (ce_v) begin
      if (sb.size() >= 2) begin
        last_exp = sb.pop_front();
        checkOutput(name, last_exp, model_sel);
      end
    end else begin
      checkOutput({name, "_hold"}, last_exp, model_sel);
    end
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) applyStimulus(name, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 9'd0, 1'b0, 24'h0);
  endtask

  task automatic pixel(input string name, input logic [9:0] xv, input logic [8:0] yv);
    applyStimulus(name, 1'b1, 1'b1, 1'b1, 1'b1, xv, yv, 1'b0, 24'h0);
  endtask

  task automatic frameBoundary();
    for (int i = 0; i < 3; i++)
      applyStimulus("blank", 1'b1, 1'b0, (i == 1) ? 1'b0 : 1'b1, 1'b1, 10'd0, 9'd0, 1'b0, 24'h0);
    for (int i = 0; i < 2; i++)
      applyStimulus("vsync", 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 24'h0);
    for (int i = 0; i < 2; i++)
      applyStimulus("back_porch", 1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 9'd0, 1'b0, 24'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_exp = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, de: 1'b0};

    vecs.push_back('{4'd1, 10'd10,  9'd0,  1'b1, 24'hFF0000});
    vecs.push_back('{4'd2, 10'd10,  9'd0,  1'b1, 24'h00FF00});
    vecs.push_back('{4'd3, 10'd10,  9'd0,  1'b1, 24'h0000FF});
    vecs.push_back('{4'd4, 10'd0,   9'd3,  1'b1, 24'hFFFFFF});
    vecs.push_back('{4'd4, 10'd79,  9'd3,  1'b1, 24'hFFFFFF});
    vecs.push_back('{4'd4, 10'd80,  9'd3,  1'b1, 24'hFFFF00});
    vecs.push_back('{4'd4, 10'd160, 9'd3,  1'b1, 24'h00FFFF});
    vecs.push_back('{4'd4, 10'd240, 9'd3,  1'b1, 24'h00FF00});
    vecs.push_back('{4'd4, 10'd320, 9'd3,  1'b1, 24'hFF00FF});
    vecs.push_back('{4'd4, 10'd400, 9'd3,  1'b1, 24'hFF0000});
    vecs.push_back('{4'd4, 10'd480, 9'd3,  1'b1, 24'h0000FF});
    vecs.push_back('{4'd4, 10'd560, 9'd3,  1'b1, 24'h000000});
    vecs.push_back('{4'd4, 10'd639, 9'd3,  1'b1, 24'h000000});
    vecs.push_back('{4'd5, 10'd0,   9'd0,  1'b1, 24'h000000});
    vecs.push_back('{4'd5, 10'd32,  9'd0,  1'b1, 24'hFFFFFF});
    vecs.push_back('{4'd5, 10'd32,  9'd32, 1'b1, 24'h000000});
    vecs.push_back('{4'd5, 10'd5,   9'd40, 1'b1, 24'hFFFFFF});
    vecs.push_back('{4'd5, 10'd32,  9'd0,  1'b0, 24'h000000});
    vecs.push_back('{4'd6, 10'd100, 9'd7,  1'b1, 24'h123456});
    vecs.push_back('{4'd7, 10'd100, 9'd7,  1'b1, 24'hABCDEF});

    // Reset held with live inputs.
    resetModel();
    rst_n = 1'b0;
    ce    = 1'b1;
    de_in = 1'b1;
    sel   = 4'd1;
    repeat (3) @(posedge clk_rgb);
    #1;
    checkOutput("reset_hold", reset_exp, 4'd0);
    de_in = 1'b0;
    rst_n = 1'b1;
    frameBoundary();

    foreach (vecs[i]) begin
      if (vecs[i].mode != model_sel) begin
        sel = vecs[i].mode;
        frameBoundary();
      end
      applyStimulus($sformatf("vec%0d", i), 1'b1, vecs[i].dev, 1'b1, 1'b1,
                    vecs[i].xv, vecs[i].yv, 1'b1, vecs[i].rgb);
    end
    idle(2, "vec_drain");

    // Single-cycle de/hs pulse must reappear exactly two cycles later.
    sel = 4'd1;
    frameBoundary();
    idle(2, "lat_pre");
    applyStimulus("lat_pulse", 1'b1, 1'b1, 1'b0, 1'b1, 10'd10, 9'd0, 1'b1, 24'hFF0000);
    idle(3, "lat_post");

    // Mid-frame change 3->6 with a toggle-and-return; blue holds until vsync.
    sel = 4'd3;
    frameBoundary();
    for (int i = 0; i < 3; i++) pixel("blue_pre", 10'(i), 9'd1);
    sel = 4'd6;
    for (int i = 0; i < 4; i++)
      applyStimulus("mid_blue", 1'b1, 1'b1, 1'b1, 1'b1, 10'(10 + i), 9'd1, 1'b1, 24'h0000FF);
    sel = 4'd2;
    for (int i = 0; i < 2; i++)
      applyStimulus("toggle_blue", 1'b1, 1'b1, 1'b1, 1'b1, 10'(20 + i), 9'd1, 1'b1, 24'h0000FF);
    sel = 4'd6;
    for (int i = 0; i < 3; i++)
      applyStimulus("return_blue", 1'b1, 1'b1, 1'b1, 1'b1, 10'(30 + i), 9'd1, 1'b1, 24'h0000FF);
    frameBoundary();
    applyStimulus("ext0", 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 24'h123456);
    idle(2, "ext_drain");

    // Clock-enable gap in the middle of a colour-bar line.
    sel = 4'd4;
    frameBoundary();
    pixel("ce_pre0", 10'd0, 9'd2);
    pixel("ce_pre1", 10'd80, 9'd2);
    pixel("ce_pre2", 10'd160, 9'd2);
    for (int i = 0; i < 10; i++)
      applyStimulus("ce_off", 1'b0, 1'b1, 1'b0, 1'b0, 10'($urandom_range(0, 639)), 9'd2, 1'b0, 24'h0);
    pixel("ce_post0", 10'd240, 9'd2);
    pixel("ce_post1", 10'd320, 9'd2);
    pixel("ce_post2", 10'd400, 9'd2);
    pixel("ce_post3", 10'd480, 9'd2);
    idle(2, "ce_drain");

    // Out-of-range selection decodes to black.
    sel = 4'd15;
    frameBoundary();
    applyStimulus("illegal", 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 24'h000000);
    idle(2, "illegal_drain");

    // Asynchronous reset in the middle of an active line.
    sel = 4'd1;
    frameBoundary();
    pixel("pre_rst0", 10'd5, 9'd9);
    pixel("pre_rst1", 10'd6, 9'd9);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", reset_exp, 4'd0);
    resetModel();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus("post_rst_black", 1'b1, 1'b1, 1'b1, 1'b1, 10'(i), 9'd9, 1'b1, 24'h000000);
    frameBoundary();
    applyStimulus("post_rst_red", 1'b1, 1'b1, 1'b1, 1'b1, 10'd3, 9'd0, 1'b1, 24'hFF0000);
    idle(2, "final_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
